bfly_eject_port: RTL and testbench
==================================

# bfly_eject_port

Endpoint receiver (ejection port) for the radix-4 butterfly network. It takes the 18-bit flit stream from a switch-node output channel and strips the head flit. Payload words go into a local FIFO, and the port presents them as a valid/ready word stream with packet-end (`last`) and error marking. The switch has no flow control, so this block absorbs the stream unconditionally and drops traffic it cannot hold.

## Interface
Parameters:
- `DEPTH`, 16: payload FIFO entries; power of two, at least 4.
- `MAX_WORDS`, 8: maximum body flits per packet.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_ch`, in, 18: flit from switch output.
  - [17:16] type: 00 null, 11 head, 10 body, 01 reserved.
  - [15:0] payload.
- `m_valid`, out, 1: output word valid.
- `m_ready`, in, 1: consumer accepts word.
- `m_data`, out, 16: payload word.
- `m_last`, out, 1: final word of packet.
- `m_err`, out, 1: packet was truncated by an error; set only when `m_last` is set.
- `pkt_cnt`, out, 16: packets closed without error; wraps.
- `err_cnt`, out, 16: protocol, length and overflow errors; saturates at FFFF.
- `drop_cnt`, out, 16: packets dropped entirely with no word output; saturates.

## Operation
- `in_ch` is sampled every rising edge. No input handshake exists.
- FSM states are IDLE, BODY and DROP.
- Reset state: IDLE, FIFO empty, staging register empty, all counters 0. `m_valid`, `m_last` and `m_err` are 0.
- Staging register holds the newest body word. The word is written to the FIFO only when the next flit is seen, so `last` is known at write time.
- "Open" flag: at least one word of the current packet is already in the FIFO.

IDLE:
- null: stay in IDLE.
- head: go to BODY, clear word count.
- body or reserved: `err_cnt`+1, stay in IDLE.

BODY, body flit:
- word count+1. If the count exceeds MAX_WORDS, treat as an error termination.
- Otherwise write the staged word with last=0, then stage the new word.

BODY, null or head flit:
- Write the staged word with last=1, err=0, then `pkt_cnt`+1.
- Empty packet (head immediately followed by null or head): `err_cnt`+1, nothing written.
- Null goes to IDLE. Head stays in BODY for a back-to-back packet.

BODY, reserved flit or error termination:
- If a word is staged, write it with last=1, err=1. Go to DROP, `err_cnt`+1.

DROP:
- Discard body flits.
- Null goes to IDLE. Head goes to BODY.
- Reserved flit: no additional count.

FIFO space reservation:
- A last=0 write requires occupancy ≤ DEPTH−2. This always leaves a slot for the terminator of an open packet.
- A last=1 write requires occupancy ≤ DEPTH−1.
- On a last=0 write failure:
  - If open: write the staged word with last=1, err=1, `err_cnt`+1, go to DROP.
  - If not open: discard the whole packet, `drop_cnt`+1, go to DROP.
- On a last=1 write failure (only possible when not open): `drop_cnt`+1.
- Occupancy for these checks is the value before this cycle's pop.

Output side:
- The output is FIFO head, shown-ahead.
- A pop occurs on `m_valid && m_ready`.
- Push and pop may occur in the same cycle; occupancy is unchanged in that case.

## Timing
- Write latency: a FIFO write occurs at the edge that samples the flit following the word. `m_valid` rises on that same edge when the FIFO was empty.
- Example: head at edge 0, DEAD at edge 1, null at edge 2. After edge 2, the output shows DEAD with `m_last`=1 and `pkt_cnt`=1.
- A held word stays stable while `m_ready`=0.
- Reset mid-packet: a partial packet is discarded. The FIFO, staging register, open flag and counters are cleared. The first edge after reset deasserts `m_valid`.
- No combinational path from `in_ch` to any output. `m_ready` affects only the pop.

## Structure
- `bfly_pkg` contains:
  - `FLIT_W`=18.
  - Enum `flit_type_e` {NULL=00, RSVD=01, BODY=10, HEAD=11}.
  - Packed struct `flit_t` {type, payload}.
  - Header field positions: dest digit [15:14].
  - State enum.
- One sub-module: `bfly_sync_fifo`, a parameterised width/depth synchronous FIFO.
  - Width 18 (data, last, err).
  - Exposes occupancy count.
  - Synchronous active-high reset.
- The FSM, staging register and counters live in `bfly_eject_port`.

## Test plan
- Single packet, `m_ready`=1: HEADER, BODY DEAD, null. Output is DEAD with last=1, err=0; `pkt_cnt`=1.
- Back-to-back packets: HEADER, BEEF, DEFE, HEADER, CA7E, null. Outputs in order:
  - BEEF, last=0
  - DEFE, last=1
  - CA7E, last=1
  - `pkt_cnt`=2
- Protocol errors:
  - Body flit F00D in IDLE: no output, `err_cnt`=1.
  - HEADER then null: no output, `err_cnt`=2.
  - HEADER, 8BAD, reserved flit: output 8BAD with last=1, err=1.
- Length overflow, MAX_WORDS=8: HEADER plus 9 body flits (words 0–8), then null.
  - Words 0–6 output with last=0.
  - Word 7 output with last=1, err=1.
  - Word 8 and the null are discarded; `err_cnt`=1.
- FIFO overflow, `m_ready`=0, DEPTH=16: a stream of MAX_WORDS packets.
  - Occupancy never exceeds 16.
  - Every open packet ends in last=1.
  - Fully blocked packets increment `drop_cnt`.
  - Raising `m_ready` drains exactly the stored words in order.
- Reset mid-packet: assert `rst` after HEADER and 3 body flits, then send a clean packet. Only the clean packet appears, and the counters reflect only the post-reset traffic.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared types and constants for the butterfly network ejection port.
package bfly_pkg;

    localparam int FLIT_W    = 18;
    localparam int PAYLOAD_W = 16;

    // Destination digit position inside a head flit payload.
    localparam int HDR_DEST_HI = 15;
    localparam int HDR_DEST_LO = 14;

    typedef enum logic [1:0] {
        NULL = 2'b00,
        RSVD = 2'b01,
        BODY = 2'b10,
        HEAD = 2'b11
    } flit_type_e;

    typedef struct packed {
        flit_type_e             ftype;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_DROP
    } state_e;

    // One payload FIFO entry.
    typedef struct packed {
        logic [PAYLOAD_W-1:0]   data;
        logic                   last;
        logic                   err;
    } fifo_word_t;

endpackage

// File: rtl/bfly_sync_fifo.sv
// Show-ahead synchronous FIFO with an occupancy count.
module bfly_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bfly_eject_port.sv
// Butterfly ejection port: strips head flits, stages body words so the
// packet end is known at write time, and buffers words with last/err tags.
module bfly_eject_port
    import bfly_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int MAX_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_ch,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       m_data,
    output logic              m_last,
    output logic              m_err,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       err_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = $clog2(MAX_WORDS + 1) + 1;
    // A last=0 write must leave one slot free for the packet terminator.
    localparam logic [AW:0]    MID_LIMIT  = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0]    LAST_LIMIT = (AW+1)'(DEPTH - 1);
    localparam logic [WCW-1:0] WC_MAX     = WCW'(MAX_WORDS);

    flit_t          flit;
    state_e         state, state_n;
    logic           stg_vld, stg_vld_n;
    logic [15:0]    stg_data, stg_data_n;
    logic           open, open_n;
    logic [WCW-1:0] wcnt, wcnt_n;
    logic           err_term;
    logic           push;
    fifo_word_t     push_word;
    fifo_word_t     head_word;
    logic [AW:0]    occ;
    logic           fifo_empty;
    logic           room_mid, room_last;
    logic           inc_pkt, inc_err, inc_drop;

    assign flit      = flit_t'(in_ch);
    assign room_mid  = (occ <= MID_LIMIT);
    assign room_last = (occ <= LAST_LIMIT);

    bfly_sync_fifo #(
        .WIDTH ($bits(fifo_word_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (m_valid && m_ready),
        .pop_data  (head_word),
        .count     (occ),
        .empty     (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = head_word.data;
    assign m_last  = m_valid && head_word.last;
    assign m_err   = m_valid && head_word.err;

    // Next-state, staging and FIFO write decisions for the sampled flit.
    always_comb begin
        state_n    = state;
        stg_vld_n  = stg_vld;
        stg_data_n = stg_data;
        open_n     = open;
        wcnt_n     = wcnt;
        err_term   = 1'b0;
        push       = 1'b0;
        push_word  = '{data: stg_data, last: 1'b0, err: 1'b0};
        inc_pkt    = 1'b0;
        inc_err    = 1'b0;
        inc_drop   = 1'b0;
        case (state)
            ST_IDLE: begin
                case (flit.ftype)
                    HEAD: begin
                        state_n   = ST_BODY;
                        wcnt_n    = '0;
                        stg_vld_n = 1'b0;
                        open_n    = 1'b0;
                    end
                    BODY, RSVD: inc_err = 1'b1;
                    default: ;
                endcase
            end
            ST_BODY: begin
                err_term = (flit.ftype == RSVD) ||
                           (flit.ftype == BODY && wcnt >= WC_MAX);
                if (err_term) begin
                    // Close what we have as an errored packet, then drop the rest.
                    if (stg_vld) begin
                        if (room_last) begin
                            push      = 1'b1;
                            push_word = '{data: stg_data, last: 1'b1, err: 1'b1};
                        end else begin
                            inc_drop = 1'b1;
                        end
                    end
                    inc_err   = 1'b1;
                    state_n   = ST_DROP;
                    stg_vld_n = 1'b0;
                    open_n    = 1'b0;
                end else if (flit.ftype == BODY) begin
                    wcnt_n = wcnt + 1'b1;
                    if (!stg_vld) begin
                        stg_vld_n  = 1'b1;
                        stg_data_n = flit.payload;
                    end else if (room_mid) begin
                        push       = 1'b1;
                        open_n     = 1'b1;
                        stg_data_n = flit.payload;
                    end else if (open) begin
                        // Reserved slot guarantees this terminator fits.
                        push      = 1'b1;
                        push_word = '{data: stg_data, last: 1'b1, err: 1'b1};
                        inc_err   = 1'b1;
                        state_n   = ST_DROP;
                        stg_vld_n = 1'b0;
                        open_n    = 1'b0;
                    end else begin
                        inc_drop  = 1'b1;
                        state_n   = ST_DROP;
                        stg_vld_n = 1'b0;
                    end
                end else begin
                    // Null or head closes the packet cleanly.
                    if (stg_vld) begin
                        if (room_last) begin
                            push      = 1'b1;
                            push_word = '{data: stg_data, last: 1'b1, err: 1'b0};
                            inc_pkt   = 1'b1;
                        end else begin
                            inc_drop = 1'b1;
                        end
                    end else begin
                        inc_err = 1'b1;
                    end
                    state_n   = (flit.ftype == HEAD) ? ST_BODY : ST_IDLE;
                    wcnt_n    = '0;
                    stg_vld_n = 1'b0;
                    open_n    = 1'b0;
                end
            end
            ST_DROP: begin
                if (flit.ftype == NULL) begin
                    state_n = ST_IDLE;
                end else if (flit.ftype == HEAD) begin
                    state_n   = ST_BODY;
                    wcnt_n    = '0;
                    stg_vld_n = 1'b0;
                    open_n    = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM, staging register and packet tracking state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            stg_vld  <= 1'b0;
            stg_data <= '0;
            open     <= 1'b0;
            wcnt     <= '0;
        end else begin
            state    <= state_n;
            stg_vld  <= stg_vld_n;
            stg_data <= stg_data_n;
            open     <= open_n;
            wcnt     <= wcnt_n;
        end
    end

    // Statistics: packet count wraps, error/drop counts saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (inc_pkt) pkt_cnt <= pkt_cnt + 1'b1;
            if (inc_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
            if (inc_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bfly_eject_port.sv
// Bench for bfly_eject_port: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a packet-level reference model.
module tb_bfly_eject_port;
    import bfly_pkg::*;

    localparam int DEPTH = 16;
    localparam int MAXW  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] in_ch;
    logic        m_valid, m_ready, m_last, m_err;
    logic [15:0] m_data, pkt_cnt, err_cnt, drop_cnt;

    always #5 clk = ~clk;

    bfly_eject_port #(.DEPTH(DEPTH), .MAX_WORDS(MAXW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_ch    (in_ch),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_err    (m_err),
        .pkt_cnt  (pkt_cnt),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [17:0] mk(input flit_type_e t, input logic [15:0] p);
        return {t, p};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] d;
        bit          last;
        bit          err;
    } word_t;

    word_t       mq[$];       // words the port should currently hold, oldest first
    int          m_mode;      // 0 waiting for head, 1 inside packet, 2 discarding
    bit          m_has;       // newest word of the packet not yet committed
    logic [15:0] m_word;
    int          m_len;       // body words accepted for this packet
    bit          m_open;      // some word of this packet already committed
    int          m_pkt, m_errs, m_drop;

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_has = 0; m_word = '0; m_len = 0; m_open = 0;
        m_pkt = 0; m_errs = 0; m_drop = 0;
    endtask

    task automatic bump_err();
        if (m_errs < 65535) m_errs++;
    endtask

    task automatic bump_drop();
        if (m_drop < 65535) m_drop++;
    endtask

    task automatic new_packet();
        m_mode = 1; m_len = 0; m_has = 0; m_open = 0;
    endtask

    task automatic model_edge(input logic [17:0] f, input bit rdy);
        int          occ;
        flit_type_e  t;
        logic [15:0] p;
        word_t       w;
        occ = mq.size();
        t   = flit_type_e'(f[17:16]);
        p   = f[15:0];
        if (occ != 0 && rdy) w = mq.pop_front();
        if (m_mode == 0) begin
            if (t == HEAD) new_packet();
            else if (t != NULL) bump_err();
        end else if (m_mode == 2) begin
            if (t == NULL) m_mode = 0;
            else if (t == HEAD) new_packet();
        end else if (t == BODY && m_len < MAXW) begin
            m_len++;
            if (!m_has) begin
                m_has = 1; m_word = p;
            end else if (occ <= DEPTH - 2) begin
                mq.push_back('{d: m_word, last: 1'b0, err: 1'b0});
                m_open = 1; m_word = p;
            end else if (m_open) begin
                mq.push_back('{d: m_word, last: 1'b1, err: 1'b1});
                bump_err(); m_mode = 2;
            end else begin
                bump_drop(); m_mode = 2;
            end
        end else if (t == BODY || t == RSVD) begin
            if (m_has) begin
                if (occ <= DEPTH - 1) mq.push_back('{d: m_word, last: 1'b1, err: 1'b1});
                else bump_drop();
            end
            bump_err(); m_mode = 2;
        end else begin
            if (m_has) begin
                if (occ <= DEPTH - 1) begin
                    mq.push_back('{d: m_word, last: 1'b1, err: 1'b0});
                    m_pkt = (m_pkt + 1) % 65536;
                end else bump_drop();
            end else bump_err();
            if (t == HEAD) new_packet();
            else m_mode = 0;
        end
    endtask

    // Drive one flit, clock it in, advance the model, settle for sampling.
    task automatic step(input logic [17:0] f, input bit rdy, input bit r = 1'b0);
        in_ch = f; m_ready = rdy; rst = r;
        @(posedge clk);
        if (r) model_reset();
        else model_edge(f, rdy);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, m_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk({tag, ".data"}, m_data, mq[0].d);
            chk({tag, ".last"}, m_last, mq[0].last);
            chk({tag, ".err"},  m_err,  mq[0].err);
        end
        chk({tag, ".pkt_cnt"},  pkt_cnt,  m_pkt);
        chk({tag, ".err_cnt"},  err_cnt,  m_errs);
        chk({tag, ".drop_cnt"}, drop_cnt, m_drop);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [17:0] f;
        bit          rdy;
        bit          v;
        logic [15:0] d;
        bit          l;
        bit          e;
        int          pc;
        int          ec;
        int          dc;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int drained;
        int lens[4];
        rst = 1'b1; in_ch = '0; m_ready = 1'b1;
        model_reset();

        tbl.push_back('{mk(HEAD, 16'h4000), 1, 0, 16'h0000, 0, 0, 0, 0, 0});
        tbl.push_back('{mk(BODY, 16'hDEAD), 1, 0, 16'h0000, 0, 0, 0, 0, 0});
        tbl.push_back('{mk(NULL, 16'h0000), 1, 1, 16'hDEAD, 1, 0, 1, 0, 0});
        tbl.push_back('{mk(NULL, 16'h0000), 1, 0, 16'h0000, 0, 0, 1, 0, 0});
        tbl.push_back('{mk(HEAD, 16'h8000), 1, 0, 16'h0000, 0, 0, 1, 0, 0});
        tbl.push_back('{mk(BODY, 16'hBEEF), 1, 0, 16'h0000, 0, 0, 1, 0, 0});
        tbl.push_back('{mk(BODY, 16'hDEFE), 1, 1, 16'hBEEF, 0, 0, 1, 0, 0});
        tbl.push_back('{mk(HEAD, 16'hC000), 1, 1, 16'hDEFE, 1, 0, 2, 0, 0});
        tbl.push_back('{mk(BODY, 16'hCA7E), 1, 0, 16'h0000, 0, 0, 2, 0, 0});
        tbl.push_back('{mk(NULL, 16'h0000), 1, 1, 16'hCA7E, 1, 0, 3, 0, 0});
        tbl.push_back('{mk(NULL, 16'h0000), 1, 0, 16'h0000, 0, 0, 3, 0, 0});
        tbl.push_back('{mk(BODY, 16'hF00D), 1, 0, 16'h0000, 0, 0, 3, 1, 0});
        tbl.push_back('{mk(HEAD, 16'h0000), 1, 0, 16'h0000, 0, 0, 3, 1, 0});
        tbl.push_back('{mk(NULL, 16'h0000), 1, 0, 16'h0000, 0, 0, 3, 2, 0});
        tbl.push_back('{mk(HEAD, 16'h4000), 1, 0, 16'h0000, 0, 0, 3, 2, 0});
        tbl.push_back('{mk(BODY, 16'h8BAD), 1, 0, 16'h0000, 0, 0, 3, 2, 0});
        tbl.push_back('{mk(RSVD, 16'h1234), 1, 1, 16'h8BAD, 1, 1, 3, 3, 0});
        tbl.push_back('{mk(NULL, 16'h0000), 0, 1, 16'h8BAD, 1, 1, 3, 3, 0});
        tbl.push_back('{mk(NULL, 16'h0000), 1, 0, 16'h0000, 0, 0, 3, 3, 0});

        // Reset state
        step('0, 1'b1, 1'b1);
        step('0, 1'b1, 1'b1);
        chk("reset.valid", m_valid, 0);
        chk("reset.last",  m_last,  0);
        chk("reset.err",   m_err,   0);
        chk("reset.pkt",   pkt_cnt, 0);
        chk("reset.errc",  err_cnt, 0);
        chk("reset.drop",  drop_cnt, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].f, tbl[i].rdy);
            chk($sformatf("tbl%0d.valid", i), m_valid, tbl[i].v);
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d.data", i), m_data, tbl[i].d);
                chk($sformatf("tbl%0d.last", i), m_last, tbl[i].l);
                chk($sformatf("tbl%0d.err", i),  m_err,  tbl[i].e);
            end
            chk($sformatf("tbl%0d.pkt", i),  pkt_cnt,  tbl[i].pc);
            chk($sformatf("tbl%0d.errc", i), err_cnt,  tbl[i].ec);
            chk($sformatf("tbl%0d.drop", i), drop_cnt, tbl[i].dc);
        end

        // Length overflow: nine body words against MAX_WORDS=8.
        step('0, 1'b1, 1'b1);
        step(mk(HEAD, 16'h0000), 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(mk(BODY, 16'h0100 + 16'(i)), 1'b1);
            check_model($sformatf("len%0d", i));
        end
        chk("len.term_data", m_data, 16'h0107);
        chk("len.term_last", m_last, 1);
        chk("len.term_err",  m_err,  1);
        for (int i = 0; i < 3; i++) begin
            step(mk(NULL, 16'h0000), 1'b1);
            check_model($sformatf("lenx%0d", i));
        end
        chk("len.errc", err_cnt, 1);
        chk("len.pkt",  pkt_cnt, 0);

        // FIFO overflow with the consumer stalled.
        step('0, 1'b0, 1'b1);
        lens = '{3, 8, 8, 8};
        for (int p = 0; p < 4; p++) begin
            step(mk(HEAD, 16'(p) << 14), 1'b0);
            for (int w = 0; w < lens[p]; w++) begin
                step(mk(BODY, 16'h1000 * 16'(p) + 16'(w)), 1'b0);
                check_model($sformatf("ovf%0d_%0d", p, w));
            end
        end
        step(mk(NULL, 16'h0000), 1'b0);
        check_model("ovf.end");
        chk("ovf.pkt",  pkt_cnt, 2);
        chk("ovf.errc", err_cnt, 1);
        chk("ovf.drop", drop_cnt, 1);
        drained = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_valid) drained++;
            step(mk(NULL, 16'h0000), 1'b1);
            check_model($sformatf("drain%0d", c));
        end
        chk("ovf.drained", drained, 16);

        // Reset in the middle of a packet.
        step('0, 1'b1, 1'b1);
        step(mk(HEAD, 16'h0000), 1'b1);
        for (int i = 0; i < 3; i++) step(mk(BODY, 16'hAA00 + 16'(i)), 1'b1);
        chk("rstmid.pre_valid", m_valid, 1);
        step('0, 1'b1, 1'b1);
        chk("rstmid.valid", m_valid, 0);
        chk("rstmid.errc",  err_cnt, 0);
        step(mk(HEAD, 16'h0000), 1'b1);
        step(mk(BODY, 16'h1234), 1'b1);
        check_model("rstmid.w0");
        step(mk(BODY, 16'h5678), 1'b1);
        check_model("rstmid.w1");
        chk("rstmid.first", m_data, 16'h1234);
        step(mk(NULL, 16'h0000), 1'b1);
        check_model("rstmid.end");
        chk("rstmid.data", m_data, 16'h5678);
        chk("rstmid.last", m_last, 1);
        chk("rstmid.pkt",  pkt_cnt, 1);
        chk("rstmid.errc2", err_cnt, 0);

        // Randomized traffic with alternating stall-heavy and free-flowing phases.
        step('0, 1'b1, 1'b1);
        for (int c = 0; c < 4000; c++) begin
            int r;
            flit_type_e t;
            bit rdy;
            r = $urandom_range(0, 99);
            if (r < 12)      t = NULL;
            else if (r < 24) t = HEAD;
            else if (r < 97) t = BODY;
            else             t = RSVD;
            if ((c / 250) % 2 == 1) rdy = ($urandom_range(0, 9) == 0);
            else                    rdy = ($urandom_range(0, 3) != 0);
            step(mk(t, 16'($urandom)), rdy);
            check_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
